// File: rtl/midi_pkg.sv
// Shared MIDI types and voice-allocator FSM encoding.
package midi_pkg;

  localparam int unsigned NumVoicesDefault = 4;
  localparam int unsigned MidiW            = 7;

  typedef logic [MidiW-1:0] key_t;
  typedef logic [MidiW-1:0] vel_t;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StMatch  = 2'b01,
    StCommit = 2'b10
  } alloc_state_e;

endpackage

// File: rtl/voice_lru.sv
// Age-rank bookkeeping: ages form a permutation of 0..NUM_VOICES-1, highest = oldest.
module voice_lru import midi_pkg::*; #(
  parameter int unsigned NUM_VOICES = NumVoicesDefault,
  parameter int unsigned AGE_W      = $clog2(NUM_VOICES)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          assign_en,
  input  logic [$clog2(NUM_VOICES)-1:0] assign_idx,
  output logic [$clog2(NUM_VOICES)-1:0] oldest_idx,
  output logic [NUM_VOICES*AGE_W-1:0]   ages
);

  localparam int unsigned IdxW = $clog2(NUM_VOICES);

  logic [AGE_W-1:0] age_q [NUM_VOICES];
  logic [AGE_W-1:0] age_d [NUM_VOICES];

  // Assigned voice becomes youngest; everything younger than its old rank ages by one.
  always_comb begin
    for (int i = 0; i < int'(NUM_VOICES); i++) begin
      age_d[i] = age_q[i];
      if (assign_en) begin
        if (IdxW'(i) == assign_idx) begin
          age_d[i] = '0;
        end else if (age_q[i] < age_q[assign_idx]) begin
          age_d[i] = age_q[i] + 1'b1;
        end
      end
    end
  end

  // Age registers; reset leaves voice 0 as the oldest.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_VOICES); i++) begin
        age_q[i] <= AGE_W'(int'(NUM_VOICES) - 1 - i);
      end
    end else begin
      age_q <= age_d;
    end
  end

  // Oldest voice is the one holding the top rank; pack ages for observers.
  always_comb begin
    oldest_idx = '0;
    ages       = '0;
    for (int i = 0; i < int'(NUM_VOICES); i++) begin
      ages[AGE_W*i +: AGE_W] = age_q[i];
      if (age_q[i] == AGE_W'(NUM_VOICES - 1)) begin
        oldest_idx = IdxW'(i);
      end
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: IDLE latches an event, MATCH registers the search
// results, COMMIT applies them. Outputs show the committed result during COMMIT.
module voice_allocator import midi_pkg::*; #(
  parameter int unsigned NUM_VOICES = NumVoicesDefault,
  parameter int unsigned AGE_W      = $clog2(NUM_VOICES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    note_on,
  input  logic [6:0]              midi_key,
  input  logic [6:0]              midi_vel,
  input  logic                    midi_valid,
  output logic [NUM_VOICES-1:0]   voice_active,
  output logic [7*NUM_VOICES-1:0] voice_key,
  output logic [7*NUM_VOICES-1:0] voice_vel,
  output logic [NUM_VOICES-1:0]   voice_trig,
  output logic                    busy,
  output logic                    drop_err
);

  localparam int unsigned IdxW = $clog2(NUM_VOICES);

  alloc_state_e state_q, state_d;
  logic         accept;

  logic ev_on_q;
  key_t ev_key_q;
  vel_t ev_vel_q;

  logic [NUM_VOICES-1:0] match_q, match_d;
  logic                  free_found_q, free_found_d;
  logic [IdxW-1:0]       free_idx_q, free_idx_d;
  logic [IdxW-1:0]       oldest_q, oldest_idx;

  logic [NUM_VOICES-1:0] active_q, active_d;
  key_t                  key_q [NUM_VOICES];
  key_t                  key_d [NUM_VOICES];
  vel_t                  vel_q [NUM_VOICES];
  vel_t                  vel_d [NUM_VOICES];
  logic                  drop_q;

  logic            is_on, commit, assign_en;
  logic [IdxW-1:0] target;

  logic [NUM_VOICES*AGE_W-1:0] ages;
  logic                        unused_ages;

  assign unused_ages = ^ages;
  assign drop_err    = drop_q;

  // FSM next state; stray encodings fall back to idle.
  always_comb begin
    state_d = StIdle;
    accept  = 1'b0;
    busy    = 1'b0;
    case (state_q)
      StIdle: begin
        if (midi_valid) begin
          accept  = 1'b1;
          state_d = StMatch;
        end
      end
      StMatch: begin
        busy    = 1'b1;
        state_d = StCommit;
      end
      StCommit: begin
        busy    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Search: key matches among active voices and the lowest-index free voice.
  always_comb begin
    match_d      = '0;
    free_found_d = 1'b0;
    free_idx_d   = '0;
    for (int i = int'(NUM_VOICES) - 1; i >= 0; i--) begin
      match_d[i] = active_q[i] && (key_q[i] == ev_key_q);
      if (!active_q[i]) begin
        free_found_d = 1'b1;
        free_idx_d   = IdxW'(i);
      end
    end
  end

  // Commit: vel=0 note-on acts as note-off; match beats free beats steal-oldest.
  always_comb begin
    is_on  = ev_on_q && (ev_vel_q != '0);
    commit = (state_q == StCommit);
    target = oldest_q;
    if (free_found_q) target = free_idx_q;
    for (int i = int'(NUM_VOICES) - 1; i >= 0; i--) begin
      if (match_q[i]) target = IdxW'(i);
    end
    assign_en  = commit && is_on;
    active_d   = active_q;
    key_d      = key_q;
    vel_d      = vel_q;
    voice_trig = '0;
    if (assign_en) begin
      active_d[target]   = 1'b1;
      key_d[target]      = ev_key_q;
      vel_d[target]      = ev_vel_q;
      voice_trig[target] = 1'b1;
    end else if (commit) begin
      active_d = active_q & ~match_q;
    end
  end

  // State, event, search-result and voice registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      ev_on_q      <= 1'b0;
      ev_key_q     <= '0;
      ev_vel_q     <= '0;
      match_q      <= '0;
      free_found_q <= 1'b0;
      free_idx_q   <= '0;
      oldest_q     <= '0;
      active_q     <= '0;
      drop_q       <= 1'b0;
      for (int i = 0; i < int'(NUM_VOICES); i++) begin
        key_q[i] <= '0;
        vel_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      key_q    <= key_d;
      vel_q    <= vel_d;
      if (accept) begin
        ev_on_q  <= note_on;
        ev_key_q <= midi_key;
        ev_vel_q <= midi_vel;
      end
      if (state_q == StMatch) begin
        match_q      <= match_d;
        free_found_q <= free_found_d;
        free_idx_q   <= free_idx_d;
        oldest_q     <= oldest_idx;
      end
      if (midi_valid && busy) drop_q <= 1'b1;
    end
  end

  // Outputs track the next-state so a commit is visible in its own cycle.
  always_comb begin
    voice_active = active_d;
    voice_key    = '0;
    voice_vel    = '0;
    for (int i = 0; i < int'(NUM_VOICES); i++) begin
      voice_key[7*i +: 7] = key_d[i];
      voice_vel[7*i +: 7] = vel_d[i];
    end
  end

  voice_lru #(
    .NUM_VOICES (NUM_VOICES),
    .AGE_W      (AGE_W)
  ) u_voice_lru (
    .clk        (clk),
    .rst        (rst),
    .assign_en  (assign_en),
    .assign_idx (target),
    .oldest_idx (oldest_idx),
    .ages       (ages)
  );

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: directed scenarios plus random events against a
// list-based LRU reference model.
module tb_voice_allocator;

  localparam int unsigned N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           note_on;
  logic [6:0]     midi_key;
  logic [6:0]     midi_vel;
  logic           midi_valid;
  logic [N-1:0]   voice_active;
  logic [7*N-1:0] voice_key;
  logic [7*N-1:0] voice_vel;
  logic [N-1:0]   voice_trig;
  logic           busy;
  logic           drop_err;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: voice table plus a recency list, least recent first.
  bit         m_active [N];
  logic [6:0] m_key    [N];
  logic [6:0] m_vel    [N];
  int         lru      [$];

  // Observations captured by do_event.
  logic           obs_busy1, obs_busy3;
  logic [N-1:0]   obs_active, obs_trig, obs_trig3;
  logic [7*N-1:0] obs_key, obs_vel;
  int             tgt;

  voice_allocator #(.NUM_VOICES(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .note_on      (note_on),
    .midi_key     (midi_key),
    .midi_vel     (midi_vel),
    .midi_valid   (midi_valid),
    .voice_active (voice_active),
    .voice_key    (voice_key),
    .voice_vel    (voice_vel),
    .voice_trig   (voice_trig),
    .busy         (busy),
    .drop_err     (drop_err)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    lru.delete();
    for (int i = 0; i < int'(N); i++) begin
      m_active[i] = 1'b0;
      m_key[i]    = '0;
      m_vel[i]    = '0;
      lru.push_back(i);
    end
  endfunction

  // Returns the voice that gets triggered, or -1.
  function automatic int model_event(bit on, logic [6:0] key, logic [6:0] vel);
    int t = -1;
    int pos = -1;
    if (on && vel != 0) begin
      for (int i = 0; i < int'(N); i++) if (t < 0 && m_active[i] && m_key[i] == key) t = i;
      for (int i = 0; i < int'(N); i++) if (t < 0 && !m_active[i]) t = i;
      if (t < 0) t = lru[0];
      m_active[t] = 1'b1;
      m_key[t]    = key;
      m_vel[t]    = vel;
      for (int k = 0; k < lru.size(); k++) if (lru[k] == t) pos = k;
      lru.delete(pos);
      lru.push_back(t);
    end else begin
      for (int i = 0; i < int'(N); i++) if (m_active[i] && m_key[i] == key) m_active[i] = 1'b0;
    end
    return t;
  endfunction

  function automatic logic [N-1:0] exp_active();
    logic [N-1:0] v;
    for (int i = 0; i < int'(N); i++) v[i] = m_active[i];
    return v;
  endfunction

  function automatic logic [7*N-1:0] exp_key();
    logic [7*N-1:0] v;
    for (int i = 0; i < int'(N); i++) v[7*i +: 7] = m_key[i];
    return v;
  endfunction

  function automatic logic [7*N-1:0] exp_vel();
    logic [7*N-1:0] v;
    for (int i = 0; i < int'(N); i++) v[7*i +: 7] = m_vel[i];
    return v;
  endfunction

  function automatic logic [N-1:0] exp_trig(int t);
    logic [N-1:0] v = '0;
    if (t >= 0) v[t] = 1'b1;
    return v;
  endfunction

  task automatic do_reset();
    rst        = 1'b1;
    midi_valid = 1'b0;
    note_on    = 1'b0;
    midi_key   = '0;
    midi_vel   = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Called at a negedge: strobes in cycle t, returns at the negedge of cycle t+3.
  task automatic do_event(input bit on, input logic [6:0] key, input logic [6:0] vel);
    note_on    = on;
    midi_key   = key;
    midi_vel   = vel;
    midi_valid = 1'b1;
    @(negedge clk);
    midi_valid = 1'b0;
    obs_busy1  = busy;
    @(negedge clk);
    obs_active = voice_active;
    obs_key    = voice_key;
    obs_vel    = voice_vel;
    obs_trig   = voice_trig;
    @(negedge clk);
    obs_trig3  = voice_trig;
    obs_busy3  = busy;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (voice_active !== '0) begin n_errors++; $display("FAIL reset_active got %h exp 0", voice_active); end
    n_checks++; if (voice_key !== '0) begin n_errors++; $display("FAIL reset_key got %h exp 0", voice_key); end
    n_checks++; if (voice_vel !== '0) begin n_errors++; $display("FAIL reset_vel got %h exp 0", voice_vel); end
    n_checks++; if (voice_trig !== '0) begin n_errors++; $display("FAIL reset_trig got %h exp 0", voice_trig); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_checks++; if (drop_err !== 1'b0) begin n_errors++; $display("FAIL reset_drop got %b exp 0", drop_err); end
  endtask

  task automatic test_first_note();
    do_reset();
    tgt = model_event(1'b1, 7'd60, 7'd100);
    do_event(1'b1, 7'd60, 7'd100);
    n_checks++; if (obs_busy1 !== 1'b1) begin n_errors++; $display("FAIL first_busy got %b exp 1", obs_busy1); end
    n_checks++; if (obs_active !== 4'b0001) begin n_errors++; $display("FAIL first_active got %b exp 0001", obs_active); end
    n_checks++; if (obs_key[6:0] !== 7'd60) begin n_errors++; $display("FAIL first_key got %0d exp 60", obs_key[6:0]); end
    n_checks++; if (obs_vel[6:0] !== 7'd100) begin n_errors++; $display("FAIL first_vel got %0d exp 100", obs_vel[6:0]); end
    n_checks++; if (obs_trig !== exp_trig(tgt)) begin n_errors++; $display("FAIL first_trig got %b exp %b", obs_trig, exp_trig(tgt)); end
    n_checks++; if (obs_trig3 !== '0) begin n_errors++; $display("FAIL first_trig_len got %b exp 0", obs_trig3); end
    n_checks++; if (obs_busy3 !== 1'b0) begin n_errors++; $display("FAIL first_busy_end got %b exp 0", obs_busy3); end
  endtask

  task automatic test_fill_steal();
    logic [6:0]   keys [5];
    logic [N-1:0] trigs [5];
    keys  = '{7'd60, 7'd62, 7'd64, 7'd65, 7'd67};
    trigs = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    for (int e = 0; e < 5; e++) begin
      tgt = model_event(1'b1, keys[e], 7'd64);
      do_event(1'b1, keys[e], 7'd64);
      n_checks++;
      if (obs_trig !== trigs[e] || obs_trig !== exp_trig(tgt))
        begin n_errors++; $display("FAIL fill_trig[%0d] got %b exp %b", e, obs_trig, trigs[e]); end
      n_checks++;
      if (obs_key !== exp_key() || obs_active !== exp_active())
        begin n_errors++; $display("FAIL fill_state[%0d] got %h/%b exp %h/%b", e, obs_key, obs_active, exp_key(), exp_active()); end
    end
    n_checks++; if (obs_key[6:0] !== 7'd67) begin n_errors++; $display("FAIL steal_key got %0d exp 67", obs_key[6:0]); end
  endtask

  task automatic test_note_off_vel0();
    do_reset();
    tgt = model_event(1'b1, 7'd60, 7'd20); do_event(1'b1, 7'd60, 7'd20);
    tgt = model_event(1'b1, 7'd62, 7'd30); do_event(1'b1, 7'd62, 7'd30);
    tgt = model_event(1'b1, 7'd60, 7'd0);  do_event(1'b1, 7'd60, 7'd0);
    n_checks++; if (obs_active !== 4'b0010 || obs_active !== exp_active()) begin n_errors++; $display("FAIL off_active got %b exp 0010", obs_active); end
    n_checks++; if (obs_key[13:7] !== 7'd62) begin n_errors++; $display("FAIL off_keep_key got %0d exp 62", obs_key[13:7]); end
    n_checks++; if (obs_trig !== '0) begin n_errors++; $display("FAIL off_trig got %b exp 0", obs_trig); end
    tgt = model_event(1'b1, 7'd70, 7'd40); do_event(1'b1, 7'd70, 7'd40);
    n_checks++; if (obs_trig !== 4'b0001 || obs_trig !== exp_trig(tgt)) begin n_errors++; $display("FAIL reuse_trig got %b exp 0001", obs_trig); end
    n_checks++; if (obs_key[6:0] !== 7'd70) begin n_errors++; $display("FAIL reuse_key got %0d exp 70", obs_key[6:0]); end
  endtask

  task automatic test_retrigger();
    do_reset();
    tgt = model_event(1'b1, 7'd60, 7'd50); do_event(1'b1, 7'd60, 7'd50);
    tgt = model_event(1'b1, 7'd60, 7'd90); do_event(1'b1, 7'd60, 7'd90);
    n_checks++; if (obs_trig !== 4'b0001) begin n_errors++; $display("FAIL retrig_trig got %b exp 0001", obs_trig); end
    n_checks++; if ($countones(obs_active) != 1) begin n_errors++; $display("FAIL retrig_count got %0d exp 1", $countones(obs_active)); end
    n_checks++; if (obs_vel !== exp_vel() || obs_vel[6:0] !== 7'd90) begin n_errors++; $display("FAIL retrig_vel got %h exp %h", obs_vel, exp_vel()); end
  endtask

  task automatic test_drop();
    do_reset();
    note_on = 1'b1; midi_key = 7'd40; midi_vel = 7'd80; midi_valid = 1'b1;
    @(negedge clk);
    midi_key = 7'd41;
    @(negedge clk);
    midi_valid = 1'b0;
    tgt = model_event(1'b1, 7'd40, 7'd80);
    n_checks++; if (voice_key !== exp_key() || voice_active !== exp_active()) begin n_errors++; $display("FAIL drop_state got %h/%b exp %h/%b", voice_key, voice_active, exp_key(), exp_active()); end
    n_checks++; if (voice_trig !== exp_trig(tgt)) begin n_errors++; $display("FAIL drop_trig got %b exp %b", voice_trig, exp_trig(tgt)); end
    n_checks++; if (drop_err !== 1'b1) begin n_errors++; $display("FAIL drop_set got %b exp 1", drop_err); end
    @(negedge clk);
    tgt = model_event(1'b0, 7'd33, 7'd10);
    do_event(1'b0, 7'd33, 7'd10);
    n_checks++; if (obs_active !== exp_active() || obs_key !== exp_key() || obs_vel !== exp_vel()) begin n_errors++; $display("FAIL unheld_off got %b exp %b", obs_active, exp_active()); end
    n_checks++; if (obs_trig !== '0) begin n_errors++; $display("FAIL unheld_trig got %b exp 0", obs_trig); end
    repeat (3) @(negedge clk);
    n_checks++; if (drop_err !== 1'b1) begin n_errors++; $display("FAIL drop_sticky got %b exp 1", drop_err); end
  endtask

  task automatic test_reset_mid_event();
    int trig_seen = 0;
    note_on = 1'b1; midi_key = 7'd50; midi_vel = 7'd70; midi_valid = 1'b1;
    @(negedge clk);
    midi_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 4; c++) begin
      if (voice_trig !== '0) trig_seen++;
      @(negedge clk);
    end
    n_checks++; if (trig_seen != 0) begin n_errors++; $display("FAIL midrst_trig got %0d pulses exp 0", trig_seen); end
    n_checks++; if (voice_active !== '0) begin n_errors++; $display("FAIL midrst_active got %b exp 0", voice_active); end
    n_checks++; if (drop_err !== 1'b0) begin n_errors++; $display("FAIL midrst_drop got %b exp 0", drop_err); end
  endtask

  task automatic test_random();
    bit         on;
    logic [6:0] key, vel;
    int         bad = 0;
    do_reset();
    for (int e = 0; e < 150; e++) begin
      on  = ($urandom_range(0, 2) != 0);
      key = 7'(60 + $urandom_range(0, 7));
      vel = ($urandom_range(0, 4) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
      tgt = model_event(on, key, vel);
      do_event(on, key, vel);
      n_checks++;
      if (obs_active !== exp_active() || obs_key !== exp_key() || obs_vel !== exp_vel() ||
          obs_trig !== exp_trig(tgt) || obs_trig3 !== '0 || obs_busy1 !== 1'b1) begin
        n_errors++; bad++;
        if (bad < 10)
          $display("FAIL rand[%0d] got act=%b key=%h vel=%h trig=%b exp act=%b key=%h vel=%h trig=%b",
                   e, obs_active, obs_key, obs_vel, obs_trig, exp_active(), exp_key(), exp_vel(), exp_trig(tgt));
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    n_checks++; if (drop_err !== 1'b0) begin n_errors++; $display("FAIL rand_drop got %b exp 0", drop_err); end
  endtask

  initial begin
    rst = 1'b1; midi_valid = 1'b0; note_on = 1'b0; midi_key = '0; midi_vel = '0;
    @(negedge clk);
    test_reset();
    test_first_note();
    test_fill_steal();
    test_note_off_vel0();
    test_retrigger();
    test_drop();
    test_reset_mid_event();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
